taillight_seq_ctrl: RTL and testbench

Controller that sequences the six tail lamps (L[2:0], R[2:0]) of the turn-signal unit. It arbitrates between left, right, hazard and brake requests and paces the three-step chase pattern from a programmable step prescaler. It replaces free-running per-clock stepping with a timed, arbitrated sequence. Its outputs drive the lamp drivers directly.

---
 rtl/taillight_seq_ctrl.sv | 142 ++++++++++++++
 tb/tb_taillight_seq_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/taillight_seq_ctrl.sv
// Tail-lamp sequencer: arbitrates turn/hazard requests and paces a three-step
// chase pattern per side, with a combinational brake overlay.
module taillight_seq_ctrl #(
   parameter int unsigned TICK_DIV = 4,
   parameter int unsigned CNT_W    = 8
) (
   input  logic       Clk,
   input  logic       reset,
   input  logic       left_req,
   input  logic       right_req,
   input  logic       hazard_req,
   input  logic       brake,
   output logic [2:0] L,
   output logic [2:0] R,
   output logic       busy,
   output logic [1:0] mode
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      GAP  = 2'd2
   } state_t;

   localparam logic [1:0]       M_NONE   = 2'b00;
   localparam logic [1:0]       M_LEFT   = 2'b01;
   localparam logic [1:0]       M_RIGHT  = 2'b10;
   localparam logic [1:0]       M_HAZ    = 2'b11;
   localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(TICK_DIV - 1);

   state_t           state, state_nx;
   logic [1:0]       step, step_nx;
   logic [1:0]       mode_q, mode_nx;
   logic [CNT_W-1:0] pre, pre_nx;
   logic [2:0]       pat;
   logic [2:0]       side_idle;

   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         step   <= 2'd0;
         mode_q <= M_NONE;
         pre    <= '0;
      end else begin
         state  <= state_nx;
         step   <= step_nx;
         mode_q <= mode_nx;
         pre    <= pre_nx;
      end
   end

   always_comb begin
      state_nx = state;
      step_nx  = step;
      mode_nx  = mode_q;
      pre_nx   = pre;
      case (state)
         IDLE: begin
            pre_nx  = '0;
            step_nx = 2'd0;
            mode_nx = M_NONE;
            if (hazard_req || (left_req && right_req)) begin
               state_nx = RUN;
               step_nx  = 2'd1;
               mode_nx  = M_HAZ;
            end else if (left_req) begin
               state_nx = RUN;
               step_nx  = 2'd1;
               mode_nx  = M_LEFT;
            end else if (right_req) begin
               state_nx = RUN;
               step_nx  = 2'd1;
               mode_nx  = M_RIGHT;
            end
         end
         RUN, GAP: begin
            // Hazard preempts a turn sequence, including its GAP step.
            if (hazard_req && mode_q != M_HAZ) begin
               state_nx = RUN;
               step_nx  = 2'd1;
               pre_nx   = '0;
               mode_nx  = M_HAZ;
            end else if (pre == PRE_LAST) begin
               pre_nx = '0;
               if (state == GAP) begin
                  state_nx = IDLE;
                  step_nx  = 2'd0;
                  mode_nx  = M_NONE;
               end else if (step == 2'd3) begin
                  state_nx = GAP;
                  step_nx  = 2'd0;
               end else begin
                  step_nx = step + 2'd1;
               end
            end else begin
               pre_nx = pre + 1'b1;
            end
         end
         default: begin
            state_nx = IDLE;
            step_nx  = 2'd0;
            mode_nx  = M_NONE;
            pre_nx   = '0;
         end
      endcase
   end

   always_comb begin
      pat = 3'b000;
      if (state == RUN) begin
         case (step)
            2'd1:    pat = 3'b001;
            2'd2:    pat = 3'b011;
            2'd3:    pat = 3'b111;
            default: pat = 3'b000;
         endcase
      end
      side_idle = brake ? 3'b111 : 3'b000;
      case (mode_q)
         M_LEFT: begin
            L = pat;
            R = side_idle;
         end
         M_RIGHT: begin
            L = side_idle;
            R = pat;
         end
         M_HAZ: begin
            L = pat;
            R = pat;
         end
         default: begin
            L = side_idle;
            R = side_idle;
         end
      endcase
   end

   assign busy = (state != IDLE);
   assign mode = mode_q;

endmodule

// File: tb/tb_taillight_seq_ctrl.sv
// Bench for taillight_seq_ctrl: directed scenarios plus random requests, each
// cycle compared against a position-in-period reference model.
module tb_taillight_seq_ctrl;

   localparam int unsigned TD = 4;

   logic       Clk = 1'b0;
   logic       reset = 1'b1;
   logic       left_req = 1'b0, right_req = 1'b0, hazard_req = 1'b0, brake = 1'b0;
   logic [2:0] L, R;
   logic       busy;
   logic [1:0] mode;

   int unsigned tests = 0;
   int unsigned fails = 0;

   // Model: active flag, latched mode and clocks elapsed since the grant.
   bit          m_act = 1'b0;
   logic [1:0]  m_mode = 2'b00;
   int unsigned m_t = 0;

   taillight_seq_ctrl #(.TICK_DIV(TD), .CNT_W(8)) dut (
      .Clk(Clk), .reset(reset), .left_req(left_req), .right_req(right_req),
      .hazard_req(hazard_req), .brake(brake), .L(L), .R(R), .busy(busy), .mode(mode)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_act  = 1'b0;
      m_mode = 2'b00;
      m_t    = 0;
   endtask

   task automatic model_edge();
      if (!m_act) begin
         if (hazard_req || (left_req && right_req)) begin
            m_act = 1'b1; m_mode = 2'b11; m_t = 0;
         end else if (left_req) begin
            m_act = 1'b1; m_mode = 2'b01; m_t = 0;
         end else if (right_req) begin
            m_act = 1'b1; m_mode = 2'b10; m_t = 0;
         end
      end else if (hazard_req && m_mode != 2'b11) begin
         m_mode = 2'b11; m_t = 0;
      end else begin
         m_t++;
         if (m_t == 4 * TD) model_reset();
      end
   endtask

   task automatic check_outputs();
      logic [2:0] pat, other, eL, eR;
      pat = 3'b000;
      if (m_act) begin
         case (m_t / TD)
            0:       pat = 3'b001;
            1:       pat = 3'b011;
            2:       pat = 3'b111;
            default: pat = 3'b000;
         endcase
      end
      other = brake ? 3'b111 : 3'b000;
      case (m_mode)
         2'b01:   begin eL = pat;   eR = other; end
         2'b10:   begin eL = other; eR = pat;   end
         2'b11:   begin eL = pat;   eR = pat;   end
         default: begin eL = other; eR = other; end
      endcase
      chk("L", L, eL);
      chk("R", R, eR);
      chk("busy", {2'b00, busy}, {2'b00, m_act});
      chk("mode", {1'b0, mode}, {1'b0, m_mode});
   endtask

   // Applies inputs mid-cycle, checks the combinational view, then crosses one edge.
   task automatic cycle(input logic l, input logic r, input logic h, input logic b);
      left_req = l; right_req = r; hazard_req = h; brake = b;
      #1 check_outputs();
      @(posedge Clk);
      model_edge();
      #1;
   endtask

   initial begin
      #1;
      chk("rst_L", L, 3'b000);
      chk("rst_R", R, 3'b000);
      chk("rst_busy", {2'b00, busy}, 3'b000);
      chk("rst_mode", {1'b0, mode}, 3'b000);
      brake = 1'b1;
      #1;
      chk("rst_brake_L", L, 3'b111);
      chk("rst_brake_R", R, 3'b111);
      brake = 1'b0;
      @(posedge Clk);
      #1 reset = 1'b0;
      model_reset();

      // Single-cycle left pulse: full sequence then idle.
      cycle(1, 0, 0, 0);
      for (int i = 0; i < 20; i++) cycle(0, 0, 0, 0);

      // Right held: repeating 17-clock period.
      for (int i = 0; i < 40; i++) cycle(0, 1, 0, 0);
      for (int i = 0; i < 18; i++) cycle(0, 0, 0, 0);

      // Left and right together select hazard.
      cycle(1, 1, 0, 0);
      for (int i = 0; i < 18; i++) cycle(0, 0, 0, 0);

      // Hazard preempting a left sequence during step 2.
      cycle(1, 0, 0, 0);
      for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0);
      cycle(0, 0, 1, 0);
      for (int i = 0; i < 20; i++) cycle(0, 0, 0, 0);

      // Brake with left, with hazard, and in idle.
      cycle(1, 0, 0, 1);
      for (int i = 0; i < 18; i++) cycle(0, 0, 0, 1);
      cycle(0, 0, 1, 1);
      for (int i = 0; i < 18; i++) cycle(0, 0, 0, 1);
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1);

      // Asynchronous reset during step 3.
      cycle(1, 0, 0, 0);
      for (int i = 0; i < 9; i++) cycle(0, 0, 0, 0);
      #2 reset = 1'b1;
      #1;
      chk("arst_L", L, 3'b000);
      chk("arst_R", R, 3'b000);
      chk("arst_busy", {2'b00, busy}, 3'b000);
      chk("arst_mode", {1'b0, mode}, 3'b000);
      model_reset();
      #2 reset = 1'b0;
      @(posedge Clk);
      #1;
      for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0);

      // Random request traffic.
      for (int i = 0; i < 400; i++)
         cycle(($urandom % 8) == 0, ($urandom % 8) == 0,
               ($urandom % 16) == 0, ($urandom % 2) == 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
